// File: rtl/rv32_pkg.sv
// Shared RV32 core types: register addresses and the pipeline controller state.
package rv32;

    typedef logic [4:0] gpr_addr_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        WFI   = 2'd2
    } pctl_state_t;

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Load-use hazard comparator: EX-stage load feeding a source register read in ID.
module load_use_detect
    import rv32::*;
(
    input  logic      ex_load,
    input  gpr_addr_t ex_dest,
    input  gpr_addr_t id_rs1,
    input  gpr_addr_t id_rs2,
    input  logic      id_rs1_used,
    input  logic      id_rs2_used,
    output logic      hazard_o
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    always_comb begin
        hazard_o = ex_load && (ex_dest != '0) &&
                   ((id_rs1_used && (id_rs1 == ex_dest)) ||
                    (id_rs2_used && (id_rs2 == ex_dest)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/squash scheduler for the five-stage pipeline, with dmem wait timeout and WFI sleep.
module pipeline_ctrl
    import rv32::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      trap_i,
    input  logic      dmem_busy_i,
    input  logic      imem_busy_i,
    input  logic      branch_taken_i,
    input  logic      ex_load_i,
    input  gpr_addr_t ex_dest_i,
    input  gpr_addr_t id_rs1_i,
    input  gpr_addr_t id_rs2_i,
    input  logic      id_rs1_used_i,
    input  logic      id_rs2_used_i,
    input  logic      wfi_i,
    input  logic      irq_pending_i,
    output logic      stall_pc_o,
    output logic      stall_if_id_o,
    output logic      stall_id_ex_o,
    output logic      stall_ex_mem_o,
    output logic      squash_if_id_o,
    output logic      squash_id_ex_o,
    output logic      squash_ex_mem_o,
    output logic      squash_mem_wb_o,
    output logic      redirect_o,
    output logic      bus_timeout_o,
    output logic      wfi_active_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    pctl_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            load_use;

    load_use_detect u_load_use (
        .ex_load     (ex_load_i),
        .ex_dest     (ex_dest_i),
        .id_rs1      (id_rs1_i),
        .id_rs2      (id_rs2_i),
        .id_rs1_used (id_rs1_used_i),
        .id_rs2_used (id_rs2_used_i),
        .hazard_o    (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = RUN;
        cnt_d   = '0;
        if (state_q == WFI) begin
            if (!trap_i && !irq_pending_i) begin
                state_d = WFI;
            end
        end else if (trap_i) begin
            state_d = RUN;
        end else if (dmem_busy_i) begin
            state_d = DWAIT;
            cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end else if (wfi_i) begin
            state_d = WFI;
        end
    end

    always_comb begin
        stall_pc_o      = 1'b0;
        stall_if_id_o   = 1'b0;
        stall_id_ex_o   = 1'b0;
        stall_ex_mem_o  = 1'b0;
        squash_if_id_o  = 1'b0;
        squash_id_ex_o  = 1'b0;
        squash_ex_mem_o = 1'b0;
        squash_mem_wb_o = 1'b0;
        redirect_o      = 1'b0;
        bus_timeout_o   = 1'b0;
        wfi_active_o    = 1'b0;
        if (!rst_n) begin
            // Flush every stage register to a bubble while held in reset.
            squash_if_id_o  = 1'b1;
            squash_id_ex_o  = 1'b1;
            squash_ex_mem_o = 1'b1;
            squash_mem_wb_o = 1'b1;
        end else if (trap_i) begin
            squash_if_id_o  = 1'b1;
            squash_id_ex_o  = 1'b1;
            squash_ex_mem_o = 1'b1;
            squash_mem_wb_o = 1'b1;
            redirect_o      = 1'b1;
        end else if (state_q == WFI || dmem_busy_i) begin
            stall_pc_o      = 1'b1;
            stall_if_id_o   = 1'b1;
            stall_id_ex_o   = 1'b1;
            stall_ex_mem_o  = 1'b1;
            squash_mem_wb_o = 1'b1;
            wfi_active_o    = (state_q == WFI);
            bus_timeout_o   = (state_q != WFI) && (cnt_q == CntLast);
        end else if (branch_taken_i) begin
            squash_if_id_o = 1'b1;
            squash_id_ex_o = 1'b1;
            redirect_o     = 1'b1;
        end else if (load_use) begin
            stall_pc_o     = 1'b1;
            stall_if_id_o  = 1'b1;
            squash_id_ex_o = 1'b1;
        end else if (imem_busy_i) begin
            stall_pc_o     = 1'b1;
            squash_if_id_o = 1'b1;
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/squash scheduler for the five-stage RV32 pipeline. Drives the hold and bubble-insert controls of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers from hazard, redirect, memory-wait and WFI conditions. It also owns the data-bus wait-timeout counter. Sits beside the datapath in the core top level; outputs are combinational from inputs plus registered state.

## Interface

- TIMEOUT_CYCLES, 255: consecutive dmem wait cycles before `bus_timeout_o` pulses; range 1..65535.

Ports (name, direction, width, meaning):

- clk  in  1  core clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- trap_i  in  1  MEM-stage instruction traps or an interrupt is taken.
- dmem_busy_i  in  1  MEM-stage data access not yet complete.
- imem_busy_i  in  1  fetch not yet returned a valid instruction.
- branch_taken_i  in  1  EX-stage branch/jump/mret redirect.
- ex_load_i  in  1  EX-stage instruction is a valid load.
- ex_dest_i  in  rv32::gpr_addr_t  EX-stage destination register.
- id_rs1_i, id_rs2_i  in  rv32::gpr_addr_t  ID-stage source registers.
- id_rs1_used_i, id_rs2_used_i  in  1  source actually read.
- wfi_i  in  1  valid WFI in MEM stage, not stalled.
- irq_pending_i  in  1  enabled interrupt pending (WFI wake).
- stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o  out  1 each  hold register.
- squash_if_id_o, squash_id_ex_o, squash_ex_mem_o, squash_mem_wb_o  out  1 each  load a bubble (`bubble`=1) next edge; overrides stall.
- redirect_o  out  1  PC loads redirect/trap target.
- bus_timeout_o  out  1  one-cycle timeout pulse.
- wfi_active_o  out  1  core sleeping.

## Operation

States (rv32::pctl_state_t): RUN, DWAIT, WFI.

Per cycle, in RUN/DWAIT, the first matching condition wins:

1. trap_i: squash all four registers, redirect_o=1. State RUN, counter 0.
2. dmem_busy_i: stall pc, if_id, id_ex and ex_mem; squash mem_wb. State DWAIT, counter +1, saturating at TIMEOUT_CYCLES.
3. branch_taken_i: squash if_id and id_ex, redirect_o=1.
4. load-use, i.e. ex_load_i and ex_dest_i≠0 and (rs1 match and used, or rs2 match and used): stall pc and if_id; squash id_ex.
5. imem_busy_i: stall pc; squash if_id.
6. Otherwise all outputs 0.

Other rules:

- With dmem_busy_i low in DWAIT: counter clears and state returns to RUN. That cycle evaluates rules 3–6 normally.
- bus_timeout_o=1 only on the cycle the counter transitions to TIMEOUT_CYCLES. The block keeps stalling until trap_i or !dmem_busy_i.
- wfi_i in RUN (rules 1–2 not active): WFI retires to WB and the state becomes WFI.
- In WFI: stall pc, if_id, id_ex and ex_mem; squash mem_wb; wfi_active_o=1.
  - irq_pending_i: return to RUN next cycle. No redirect from this block.
  - trap_i: rule 1 applies immediately.

## Timing

- All outputs are combinational from current inputs and state, with zero-cycle latency. The state and counter update on the rising clk edge.
- Asynchronous reset: state=RUN and counter=0 immediately.
- While rst_n=0: all squash outputs =1; all stall outputs, redirect_o, bus_timeout_o and wfi_active_o =0.
- Reset mid-DWAIT or mid-WFI drops the block straight to RUN. No timeout pulse is emitted.
- Simultaneous trap_i and dmem_busy_i: trap wins; the counter clears.
- Simultaneous branch_taken_i and load-use: branch wins. The ID instruction is squashed, so no stall is applied.
- For TIMEOUT_CYCLES=1, the pulse fires on the first DWAIT cycle.

## Structure

- Add to the rv32 package: `pctl_state_t` enum {RUN, DWAIT, WFI}. Reuse `gpr_addr_t`.
- Counter width: $clog2(TIMEOUT_CYCLES+1), computed locally.
- One combinational sub-module, `load_use_detect`, holding the comparator of rule 4. Its ports are ex_load, ex_dest, id_rs1/2, used flags and hazard_o.

## Test plan

- Load-use: ex_load_i=1, ex_dest_i=5, id_rs2_i=5, id_rs2_used_i=1 → stall_pc_o=stall_if_id_o=squash_id_ex_o=1 for one cycle. The same stimulus with ex_dest_i=0 gives all outputs 0.
- Branch plus load-use in the same cycle → squash_if_id_o=squash_id_ex_o=redirect_o=1, no stalls.
- TIMEOUT_CYCLES=4, dmem_busy_i held 6 cycles:
  - bus_timeout_o high only in cycle 4.
  - Stalls and squash_mem_wb_o=1 hold all 6 cycles.
  - Cycle 7 is back in RUN with counter=0.
- trap_i asserted in DWAIT cycle 2 → all squashes=1 and redirect_o=1 that cycle. Next cycle is RUN; no timeout pulse.
- wfi_i pulse, then 10 idle cycles, then irq_pending_i:
  - wfi_active_o=1 for exactly those 10 cycles plus the irq cycle.
  - Outputs all 0 the cycle after.
- rst_n dropped asynchronously mid-WFI → squash outputs =1 immediately, wfi_active_o=0. After release the state is RUN.
